clint_multi: RTL



---
 rtl/clint_if.sv | 21 ++
 rtl/clint_multi.sv | 123 ++++++++++++
 2 files changed

// File: rtl/clint_if.sv
// Peripheral-bus request/response channel between a bus master and the CLINT.
// valid is a one-cycle request pulse; ready answers it exactly one cycle later.
interface clint_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output valid, instr, addr, wdata, wstrb,
        input  rdata, ready
    );

    modport slave (
        input  valid, instr, addr, wdata, wstrb,
        output rdata, ready
    );
endinterface

// File: rtl/clint_multi.sv
// Multi-hart core-local interruptor: shared prescaled 64-bit mtime, per-hart mtimecmp and
// msip, registered per-hart timer interrupt outputs, byte-strobe register writes.
module clint_multi #(
    parameter int unsigned NUM_HARTS     = 2,
    parameter int unsigned CLK_DIV       = 50,
    parameter int unsigned MTIMECMP_BASE = 16384,
    parameter int unsigned MTIME_BASE    = 49144
) (
    input  logic                 clk,
    input  logic                 rst,
    clint_if.slave               bus,
    output logic [63:0]          clint_mtime,
    output logic [NUM_HARTS-1:0] clint_msip,
    output logic [NUM_HARTS-1:0] clint_mtip
);
    localparam int unsigned   CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [63:0]          mtime_q, mtime_d;
    logic [63:0]          mtimecmp_q [NUM_HARTS];
    logic [63:0]          mtimecmp_d [NUM_HARTS];
    logic [NUM_HARTS-1:0] msip_q, msip_d;
    logic [NUM_HARTS-1:0] mtip_q;
    logic                 ready_q;
    logic [31:0]          rdata_q, rdata_d;

    logic        tick;
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] cmp_off;
    logic        msip_hit, cmp_hit, mtime_lo_hit, mtime_hi_hit;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
        end
        return res;
    endfunction

    assign tick = (cnt_q == CNT_MAX);
    // Instruction fetches are never allowed to modify state.
    assign wr   = bus.valid && !bus.instr && (bus.wstrb != 4'b0000);

    assign waddr        = bus.addr & 32'hFFFF_FFFC;
    assign cmp_off      = waddr - MTIMECMP_BASE;
    assign msip_hit     = (waddr < 4 * NUM_HARTS);
    assign cmp_hit      = (waddr >= MTIMECMP_BASE) && (cmp_off < 8 * NUM_HARTS);
    assign mtime_lo_hit = (waddr == MTIME_BASE);
    assign mtime_hi_hit = (waddr == MTIME_BASE + 4);

    always_comb begin
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        rdata_d    = '0;

        if (bus.valid) begin
            for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                if (msip_hit && ((waddr >> 2) == h)) begin
                    if (wr) begin
                        if (bus.wstrb[0]) msip_d[h] = bus.wdata[0];
                    end else begin
                        rdata_d = {31'b0, msip_q[h]};
                    end
                end
                if (cmp_hit && ((cmp_off >> 3) == h)) begin
                    if (cmp_off[2]) begin
                        if (wr) mtimecmp_d[h][63:32] =
                            merge(mtimecmp_q[h][63:32], bus.wdata, bus.wstrb);
                        else rdata_d = mtimecmp_q[h][63:32];
                    end else begin
                        if (wr) mtimecmp_d[h][31:0] =
                            merge(mtimecmp_q[h][31:0], bus.wdata, bus.wstrb);
                        else rdata_d = mtimecmp_q[h][31:0];
                    end
                end
            end
            // A software write to mtime replaces this cycle's increment, with no carry.
            if (mtime_lo_hit) begin
                if (wr) mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], bus.wdata, bus.wstrb)};
                else rdata_d = mtime_q[31:0];
            end
            if (mtime_hi_hit) begin
                if (wr) mtime_d = {merge(mtime_q[63:32], bus.wdata, bus.wstrb), mtime_q[31:0]};
                else rdata_d = mtime_q[63:32];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            mtime_q <= '0;
            for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                mtimecmp_q[h] <= '1;
            end
            msip_q  <= '0;
            mtip_q  <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            mtime_q <= mtime_d;
            for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                mtimecmp_q[h] <= mtimecmp_d[h];
                mtip_q[h]     <= (mtime_q >= mtimecmp_q[h]);
            end
            msip_q  <= msip_d;
            ready_q <= bus.valid;
            rdata_q <= rdata_d;
        end
    end

    assign bus.ready   = ready_q;
    assign bus.rdata   = rdata_q;
    assign clint_mtime = mtime_q;
    assign clint_msip  = msip_q;
    assign clint_mtip  = mtip_q;
endmodule
